// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the data-memory load/store port.
//   lsu_state_e  : control FSM states
//   lsu_fault_e  : response fault codes (encoding is the resp_fault value)
//   F3_*         : RV32I load/store width/sign encodings
//   check_fault  : first-match fault classification of a request
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RESP      = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_FUNCT3   = 2'b10,
        FLT_RANGE    = 2'b11
    } lsu_fault_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal encoding beats misalignment, which beats out-of-range.
    // The range test uses a wrapping 32-bit subtract so addresses below
    // the window base land far above the window size.
    function automatic lsu_fault_e check_fault(
        input logic        is_store,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic        legal;
        logic [31:0] offset;
        offset = addr - base;
        if (is_store)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);

        if (!legal)
            check_fault = FLT_FUNCT3;
        else if ((funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3 == F3_W && addr[1:0] != 2'b00))
            check_fault = FLT_MISALIGN;
        else if (offset >= size)
            check_fault = FLT_RANGE;
        else
            check_fault = FLT_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data alignment and extension.
//   rdata  in  32  raw memory word
//   offset in  2   byte offset of the access within the word
//   funct3 in  3   width/sign of the load
//   result out 32  lane-shifted, sign- or zero-extended load value
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port: load/store initiator for the core's data memory port.
// One access per request, at most one outstanding; the response is
// registered and held until writeback takes it.
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_is_store, req_funct3,
//   req_addr, req_wdata, req_rd    access description
//   resp_valid/resp_ready          response handshake
//   resp_data, resp_rd,
//   resp_is_store, resp_fault      registered response
//   mem_addr, mem_wdata, mem_we,
//   mem_re, mem_rdata              memory port (1-cycle read latency)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request; memory strobes driven from it
// LOAD_WAIT | read issued last cycle; align mem_rdata into resp_data
// RESP      | response valid, waiting for resp_ready
module lsu_dmem_port
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter int unsigned DMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_is_store,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    lsu_fault_e  req_fault;
    logic        req_ok;
    logic [31:0] load_result;

    assign req_fault = check_fault(req_is_store, req_funct3, req_addr,
                                   DMEM_BASE, 32'(DMEM_BYTES));
    assign req_ok    = (req_fault == FLT_NONE);
    assign req_ready = (state == IDLE);

    // Strobes only for a live, fault-free request while idle, so a store
    // commits exactly on its acceptance edge.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 4'd0;
        mem_re    = 1'b0;
        if (state == IDLE && req_valid && req_ok) begin
            mem_addr = {req_addr[31:2], 2'b00};
            if (req_is_store) begin
                case (req_funct3)
                    F3_B: begin
                        mem_we    = 4'b0001 << req_addr[1:0];
                        mem_wdata = {4{req_wdata[7:0]}};
                    end
                    F3_H: begin
                        mem_we    = 4'b0011 << req_addr[1:0];
                        mem_wdata = {2{req_wdata[15:0]}};
                    end
                    default: begin
                        mem_we    = 4'b1111;
                        mem_wdata = req_wdata;
                    end
                endcase
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            offset_q      <= 2'd0;
            funct3_q      <= 3'd0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'd0;
            resp_rd       <= 5'd0;
            resp_is_store <= 1'b0;
            resp_fault    <= FLT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        offset_q      <= req_addr[1:0];
                        funct3_q      <= req_funct3;
                        resp_rd       <= req_rd;
                        resp_is_store <= req_is_store;
                        resp_fault    <= req_fault;
                        resp_data     <= 32'd0;
                        if (!req_is_store && req_ok) begin
                            state <= LOAD_WAIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    resp_data  <= load_result;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb_lsu_dmem_port: directed test of lsu_dmem_port against a byte-level
// reference memory model with a per-cycle response checker.
module tb_lsu_dmem_port;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          BYTES = 16384;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_is_store;
    logic [1:0]  resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    lsu_dmem_port #(.DMEM_BASE(BASE), .DMEM_BYTES(BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_rd       (resp_rd),
        .resp_is_store (resp_is_store),
        .resp_fault    (resp_fault),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic outstanding = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM seen by the DUT: registered read, byte-enabled write.
    logic [31:0] ram [0:4095];
    // Reference image, one entry per byte.
    logic [7:0]  gmem [0:16383];

    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (mem_we[l]) ram[mem_addr[13:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
        if (mem_re) mem_rdata <= ram[mem_addr[13:2]];
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        st;
        logic [1:0]  fault;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one access, computed from byte addresses.
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [1:0] flt, output logic [31:0] ldata,
                                  output logic [3:0] we, output logic [31:0] wd);
        int          size;
        bit          sgn;
        logic [31:0] off;
        longint      v;
        flt = 2'b00; ldata = 32'd0; we = 4'd0; wd = 32'd0;
        size = 0; sgn = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        if (st && size != 0 && f3[2]) size = 0;
        off = a - BASE;
        if (size == 0)                        flt = 2'b10;
        else if ((int'(a[1:0]) % size) != 0)  flt = 2'b01;
        else if (off >= 32'(BYTES))           flt = 2'b11;
        else if (st) begin
            for (int i = 0; i < size; i++) begin
                we[int'(a[1:0]) + i] = 1'b1;
                gmem[off + 32'(i)] = d[8*i +: 8];
            end
            wd = (size == 1) ? {4{d[7:0]}} : (size == 2) ? {2{d[15:0]}} : d;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++)
                v = v + (longint'(gmem[off + 32'(i)]) << (8*i));
            if (sgn && v >= (longint'(1) << (8*size - 1)))
                v = v - (longint'(1) << (8*size));
            ldata = v[31:0];
        end
    endfunction

    // Per-cycle response checker.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ev;
            ev = (q.size() > 0) && (cyc >= q[0].due);
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("req_ready", 32'(req_ready), 32'(!outstanding));
            chk("mem_we_quiet", 32'(mem_we), 32'd0);
            chk("mem_re_quiet", 32'(mem_re), 32'd0);
            if (ev) begin
                chk("resp_data", resp_data, q[0].data);
                chk("resp_rd", 32'(resp_rd), 32'(q[0].rd));
                chk("resp_is_store", 32'(resp_is_store), 32'(q[0].st));
                chk("resp_fault", 32'(resp_fault), 32'(q[0].fault));
            end
        end
    end

    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input int stall,
                          output logic [31:0] got);
        logic [1:0]  flt;
        logic [31:0] ld, ewd;
        logic [3:0]  ewe;
        bit          imm;
        int          n;
        model(st, f3, a, d, flt, ld, ewe, ewd);
        imm = st || (flt != 2'b00);
        @(negedge clk); #1;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = d; req_rd = rd;
        #1;
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_re", 32'(mem_re), 32'(!imm));
        chk("mem_addr", mem_addr, (flt == 2'b00) ? {a[31:2], 2'b00} : 32'd0);
        if (st && flt == 2'b00) chk("mem_wdata", mem_wdata, ewd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        outstanding = 1'b1;
        q.push_back('{data: imm ? 32'd0 : ld, rd: rd, st: st, fault: flt,
                      due: cyc + (imm ? 0 : 1)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 8);
        chk("resp_latency", 32'(n), imm ? 32'd1 : 32'd2);
        got = resp_data;
        repeat (stall) @(negedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        void'(q.pop_front());
        outstanding = 1'b0;
        #1 resp_ready = 1'b0;
    endtask

    logic [31:0] got;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b0;
        mem_rdata = 32'd0;
        for (int w = 0; w < 4096; w++) begin
            logic [31:0] word;
            word = $urandom;
            ram[w] = word;
            for (int b = 0; b < 4; b++) gmem[4*w + b] = word[8*b +: 8];
        end
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_is_store", 32'(resp_is_store), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        #1 rst_n = 1'b1;

        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 0, got);
        chk("sw_ram", ram[4], 32'hDEADBEEF);
        access(1'b1, 3'b000, 32'h13, 32'h000000A5, 5'd2, 0, got);
        chk("sb_ram", ram[4], 32'hA5ADBEEF);
        access(1'b0, 3'b100, 32'h13, 32'h0, 5'd3, 0, got);
        chk("lbu_lit", got, 32'h000000A5);
        access(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 0, got);
        chk("lb_lit", got, 32'hFFFFFFA5);
        access(1'b0, 3'b001, 32'h12, 32'h0, 5'd5, 0, got);
        chk("lh_lit", got, 32'hFFFFA5AD);
        access(1'b0, 3'b101, 32'h12, 32'h0, 5'd6, 0, got);
        chk("lhu_lit", got, 32'h0000A5AD);
        access(1'b0, 3'b010, 32'h10, 32'h0, 5'd7, 0, got);
        chk("lw_lit", got, 32'hA5ADBEEF);

        access(1'b0, 3'b010, 32'h6, 32'h0, 5'd8, 0, got);
        chk("lw_mis_data", got, 32'd0);
        access(1'b1, 3'b001, 32'h1, 32'h1234, 5'd9, 0, got);
        access(1'b0, 3'b000, BASE + 32'd16384, 32'h0, 5'd10, 0, got);
        access(1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 5'd11, 0, got);
        access(1'b1, 3'b100, 32'h20, 32'h55, 5'd12, 0, got);
        access(1'b0, 3'b011, 32'h20, 32'h0, 5'd13, 0, got);
        access(1'b0, 3'b111, 32'h20, 32'h0, 5'd14, 0, got);
        access(1'b1, 3'b011, 32'h20, 32'h0, 5'd15, 0, got);

        access(1'b1, 3'b001, 32'h22, 32'h1234BEEF, 5'd16, 0, got);
        access(1'b0, 3'b001, 32'h22, 32'h0, 5'd17, 0, got);
        chk("lh_hi_lit", got, 32'hFFFFBEEF);
        access(1'b1, 3'b000, 32'h3FFF, 32'h0000007E, 5'd18, 0, got);
        access(1'b0, 3'b100, 32'h3FFF, 32'h0, 5'd19, 0, got);
        chk("lbu_top_lit", got, 32'h0000007E);

        access(1'b0, 3'b010, 32'h10, 32'h0, 5'd20, 5, got);
        access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd21, 3, got);
        access(1'b0, 3'b010, 32'h40, 32'h0, 5'd22, 0, got);

        // Reset while a load is in flight.
        @(negedge clk); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_rd = 5'd23;
        @(posedge clk); #1;
        req_valid = 1'b0;
        outstanding = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        outstanding = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        access(1'b0, 3'b000, 32'h40, 32'h0, 5'd24, 0, got);
        chk("post_rst_lb", got, 32'h0000000D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
